// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART core with 16x baud generator, FIFOs and flow control
// Show-ahead FIFO used for both directions; head reads as zero when empty.

module uart_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   syncReset,
    input  logic                   flush,
    input  logic [W-1:0]           wrData,
    input  logic                   wrValid,
    output logic                   wrReady,
    output logic [W-1:0]           rdData,
    output logic                   rdValid,
    input  logic                   rdReady,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign wrReady = (count != FULL_COUNT);
    assign rdValid = (count != '0);
    assign doPush  = wrValid && wrReady;
    assign doPop   = rdReady && rdValid;
    assign rdData  = rdValid ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (syncReset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end
endmodule

module uart_core_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        syncReset,
    input  logic [DIV_W-1:0]            divisor,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           tx_wdata,
    input  logic                        tx_wvalid,
    output logic                        tx_wready,
    output logic [DATA_W-1:0]           rx_rdata,
    output logic                        rx_rvalid,
    input  logic                        rx_rready,
    output logic [$clog2(FIFO_DEPTH):0] tx_count,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    input  logic                        rx,
    output logic                        tx,
    input  logic                        cts,
    output logic                        rts,
    output logic                        err_frame,
    output logic                        err_parity,
    output logic                        err_overrun,
    input  logic                        err_clear
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RTS_LEVEL = CW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_W - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

    // Oversample tick; compare with >= so a shrinking divisor never stalls the counter.
    logic [DIV_W-1:0] tickCnt;
    logic             tick;

    assign tick = (tickCnt >= divisor);

    always_ff @(posedge clk) begin
        if (syncReset || tick) tickCnt <= '0;
        else                   tickCnt <= tickCnt + 1'b1;
    end

    logic [DATA_W-1:0] txHead;
    logic              txHeadValid;
    logic              txStart;
    txState_t          txState, txStateNext;
    logic [3:0]        txTicks, txTicksNext;
    logic [3:0]        txBits, txBitsNext;
    logic [DATA_W-1:0] txShift, txShiftNext;
    logic              txParBit, txParBitNext;
    logic              txParEn, txParEnNext;
    logic              txStop2, txStop2Next;
    logic              txWindowEnd;

    uart_core_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) txFifo (
        .clk(clk), .syncReset(syncReset), .flush(flush),
        .wrData(tx_wdata), .wrValid(tx_wvalid), .wrReady(tx_wready),
        .rdData(txHead), .rdValid(txHeadValid), .rdReady(txStart),
        .count(tx_count)
    );

    assign txStart     = (txState == TX_IDLE) && tick && txHeadValid && cts;
    assign txWindowEnd = tick && (txTicks == 4'd15);

    always_comb begin
        txStateNext  = txState;
        txTicksNext  = (tick && txState != TX_IDLE) ? txTicks + 4'd1 : txTicks;
        txBitsNext   = txBits;
        txShiftNext  = txShift;
        txParBitNext = txParBit;
        txParEnNext  = txParEn;
        txStop2Next  = txStop2;
        tx           = 1'b1;
        case (txState)
            TX_IDLE: begin
                if (txStart) begin
                    txStateNext  = TX_START;
                    txTicksNext  = 4'd0;
                    txBitsNext   = 4'd0;
                    txShiftNext  = txHead;
                    txParBitNext = (^txHead) ^ (cfg_parity == 2'b10);
                    txParEnNext  = cfg_parity[0] ^ cfg_parity[1];
                    txStop2Next  = cfg_stop2;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (txWindowEnd) txStateNext = TX_DATA;
            end
            TX_DATA: begin
                tx = txShift[0];
                if (txWindowEnd) begin
                    txShiftNext = txShift >> 1;
                    if (txBits == LAST_BIT) txStateNext = txParEn ? TX_PARITY : TX_STOP1;
                    else                    txBitsNext  = txBits + 4'd1;
                end
            end
            TX_PARITY: begin
                tx = txParBit;
                if (txWindowEnd) txStateNext = TX_STOP1;
            end
            TX_STOP1: begin
                if (txWindowEnd) txStateNext = txStop2 ? TX_STOP2 : TX_IDLE;
            end
            TX_STOP2: begin
                if (txWindowEnd) txStateNext = TX_IDLE;
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syncReset || flush) begin
            txState  <= TX_IDLE;
            txTicks  <= '0;
            txBits   <= '0;
            txShift  <= '0;
            txParBit <= 1'b0;
            txParEn  <= 1'b0;
            txStop2  <= 1'b0;
        end else begin
            txState  <= txStateNext;
            txTicks  <= txTicksNext;
            txBits   <= txBitsNext;
            txShift  <= txShiftNext;
            txParBit <= txParBitNext;
            txParEn  <= txParEnNext;
            txStop2  <= txStop2Next;
        end
    end

    logic              rxMeta, rxSync, rxPrev;
    rxState_t          rxState, rxStateNext;
    logic [3:0]        rxTicks, rxTicksNext;
    logic [3:0]        rxBits, rxBitsNext;
    logic [DATA_W-1:0] rxShift, rxShiftNext;
    logic              rxParEn, rxParEnNext;
    logic              rxOdd, rxOddNext;
    logic              rxParErr, rxParErrNext;
    logic              rxDone, rxDoneNext;
    logic              rxStopBit, rxStopBitNext;
    logic              rxSample, rxWindowEnd;
    logic              rxFifoReady, rxPush;

    always_ff @(posedge clk) begin
        if (syncReset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign rxSample    = tick && (rxTicks == 4'd7);
    assign rxWindowEnd = tick && (rxTicks == 4'd15);

    always_comb begin
        rxStateNext   = rxState;
        rxTicksNext   = (tick && rxState != RX_IDLE) ? rxTicks + 4'd1 : rxTicks;
        rxBitsNext    = rxBits;
        rxShiftNext   = rxShift;
        rxParEnNext   = rxParEn;
        rxOddNext     = rxOdd;
        rxParErrNext  = rxParErr;
        rxDoneNext    = 1'b0;
        rxStopBitNext = rxStopBit;
        case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxSync) begin
                    rxStateNext  = RX_START;
                    rxTicksNext  = 4'd0;
                    rxBitsNext   = 4'd0;
                    rxParEnNext  = cfg_parity[0] ^ cfg_parity[1];
                    rxOddNext    = (cfg_parity == 2'b10);
                    rxParErrNext = 1'b0;
                end
            end
            RX_START: begin
                if (rxSample && rxSync) rxStateNext = RX_IDLE;
                else if (rxWindowEnd)   rxStateNext = RX_DATA;
            end
            RX_DATA: begin
                if (rxSample) rxShiftNext = {rxSync, rxShift[DATA_W-1:1]};
                if (rxWindowEnd) begin
                    if (rxBits == LAST_BIT) rxStateNext = rxParEn ? RX_PARITY : RX_STOP;
                    else                    rxBitsNext  = rxBits + 4'd1;
                end
            end
            RX_PARITY: begin
                if (rxSample)    rxParErrNext = rxSync != ((^rxShift) ^ rxOdd);
                if (rxWindowEnd) rxStateNext  = RX_STOP;
            end
            RX_STOP: begin
                // Leave at the stop sample so a back-to-back start edge is not missed.
                if (rxSample) begin
                    rxDoneNext    = 1'b1;
                    rxStopBitNext = rxSync;
                    rxStateNext   = RX_IDLE;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syncReset || flush) begin
            rxState   <= RX_IDLE;
            rxTicks   <= '0;
            rxBits    <= '0;
            rxShift   <= '0;
            rxParEn   <= 1'b0;
            rxOdd     <= 1'b0;
            rxParErr  <= 1'b0;
            rxDone    <= 1'b0;
            rxStopBit <= 1'b1;
        end else begin
            rxState   <= rxStateNext;
            rxTicks   <= rxTicksNext;
            rxBits    <= rxBitsNext;
            rxShift   <= rxShiftNext;
            rxParEn   <= rxParEnNext;
            rxOdd     <= rxOddNext;
            rxParErr  <= rxParErrNext;
            rxDone    <= rxDoneNext;
            rxStopBit <= rxStopBitNext;
        end
    end

    assign rxPush = rxDone && rxStopBit && rxFifoReady;

    uart_core_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) rxFifo (
        .clk(clk), .syncReset(syncReset), .flush(flush),
        .wrData(rxShift), .wrValid(rxPush), .wrReady(rxFifoReady),
        .rdData(rx_rdata), .rdValid(rx_rvalid), .rdReady(rx_rready),
        .count(rx_count)
    );

    assign rts = (rx_count >= RTS_LEVEL);

    always_ff @(posedge clk) begin
        if (syncReset) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= (rxDone && !rxStopBit) || (err_frame && !err_clear);
            err_overrun <= (rxDone && rxStopBit && !rxFifoReady) || (err_overrun && !err_clear);
            err_parity  <= (rxPush && rxParErr) || (err_parity && !err_clear);
        end
    end
endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised full-duplex UART core with an integrated 16x oversampling baud generator, configurable frame format (data width, parity, stop bits), show-ahead TX/RX FIFOs of parameterised depth, RTS/CTS flow control and sticky error reporting. It replaces the fixed 8N1 UART-plus-FIFO wrapper: the host side uses valid/ready handshakes instead of edge-detected control codes, and the baud rate is a programmable divisor instead of a fixed rate table. It sits between the bus-slave register block and the chip pads.

## Interface
- DATA_W, 8: data bits per frame, 5..9, LSB first on the line.
- FIFO_DEPTH, 16: entries per FIFO, power of two, >= 4.
- DIV_W, 16: divisor width.
- clk  in  1  core clock.
- syncReset  in  1  reset; one clock; reset is synchronous and active-high.
- divisor  in  DIV_W  oversample tick period minus 1; tick every divisor+1 clocks.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 = two stop bits on TX; RX always checks the first stop bit only.
- flush  in  1  single-cycle clear of both FIFOs and both engines.
- tx_wdata  in  DATA_W  byte to send.
- tx_wvalid / tx_wready  in / out  1  push handshake; tx_wready = TX FIFO not full.
- rx_rdata  out  DATA_W  RX FIFO head; 0 when empty.
- rx_rvalid / rx_rready  out / in  1  pop handshake; rx_rvalid = RX FIFO not empty.
- tx_count, rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rx  in  1  serial input (asynchronous).
- tx  out  1  serial output, idle high.
- cts  in  1  1 = far end accepts data.
- rts  out  1  1 = RX FIFO count >= FIFO_DEPTH-1 (far end must pause).
- err_frame, err_parity, err_overrun  out  1  sticky error flags.
- err_clear  in  1  clears all three flags.

## Operation
- Tick generator: counter counts up each clk; on count >= divisor it emits tick and reloads to 0. A shrinking divisor therefore takes effect on the next tick without stalling.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP1 -> STOP2 (only if cfg_stop2) -> IDLE. Each state lasts 16 ticks.
- Leaving IDLE: on a tick when the TX FIFO is non-empty and cts=1, pop the head and latch the data, cfg_parity and cfg_stop2 for the whole frame.
- cts is sampled only at frame start. Deasserting it mid-frame does not abort the frame.
- Parity: even = XOR of the data bits; odd = its inverse.
- RX path: rx passes through a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- In IDLE, a synchronised falling edge starts START and resets the oversample counter.
- START is re-sampled at tick 8. If it reads high, the event is a false start: return to IDLE with no flag.
- Every later bit is sampled at tick 8 of its 16-tick window.
- End of frame (at the STOP sample):
  - stop=0: set err_frame and discard the byte.
  - otherwise, RX FIFO full: set err_overrun and discard the byte.
  - otherwise: push the byte. On parity mismatch, set err_parity and still push the byte.
- After STOP the RX FSM returns to IDLE immediately, which allows back-to-back frames.
- FIFOs are show-ahead circular buffers with pointer wrap at FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged; this is legal when full or empty only if the side concerned is valid.
  - A push while full or a pop while empty is ignored, which the handshake prevents.
- flush: both FIFOs empty, the TX frame aborts, tx=1 the next cycle, and RX returns to IDLE. Error flags are unaffected.
- err_clear in the same cycle as a new error: the error wins and the flag stays set.

## Timing
- Reset values: tx=1, rts=0, tx_wready=1, rx_rvalid=0, rx_rdata=0, counts=0, all err flags=0, both FSMs IDLE, tick counter 0.
- Handshakes complete on the clk edge where valid&ready. Counts, wready and rvalid update in the following cycle.
- TX latency: the start bit appears on tx at most divisor+2 clocks after the first accepted byte reaches an empty FIFO with the engine IDLE and cts=1.
- One bit time is 16*(divisor+1) clocks.
- RX push happens 1 clk after the STOP sample tick. The rx_rvalid rise and rts update follow 1 clk later.
- A syncReset asserted mid-frame overrides everything: all state returns to reset values at the next edge.

## Test plan
- divisor=1, 8N1, cts=1, push 0xA5 -> tx low for 32 clks, then bits 1,0,1,0,0,1,0,1 at 32 clks each, then high. tx_count goes 1 -> 0 at frame start.
- Loopback tx->rx with cfg_parity=01, cfg_stop2=1, bytes 0x00, 0xFF, 0x3C -> the same three bytes pop in order and no error flags are set.
- Drive a frame with the wrong parity bit for 0x55, odd parity -> 0x55 is pushed and err_parity=1. err_clear then drops the flag.
- Drive a frame with stop=0 -> no push and err_frame=1. A 3-tick glitch low on idle rx -> nothing pushed and no flag.
- With FIFO_DEPTH=4, receive 5 frames without popping -> rts=1 after the 3rd, rx_count=4 after the 4th, and the 5th is dropped with err_overrun=1.
- Hold cts=0 with 2 bytes queued -> tx stays high. Raise cts -> both frames are sent. Drop cts mid-frame -> the current frame completes and the next is withheld.
